// File: rtl/traffic_controller_nway.sv
// N-approach round-robin intersection controller with min/max green, yellow and all-red clearance.
// Optional emergency preemption is compiled in when PREEMPT_EN is defined.
module traffic_controller_nway #(
    parameter int N_DIR       = 4,
    parameter int IDX_W       = 2,
    parameter int CNT_W       = 8,
    parameter int T_MIN_GREEN = 10,
    parameter int T_MAX_GREEN = 40,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 2,
    parameter int HOME_DIR    = 0
) (
    input  logic               clk,
    input  logic               clear,
    input  logic [N_DIR-1:0]   req,
`ifdef PREEMPT_EN
    input  logic               preempt,
    input  logic [IDX_W-1:0]   preempt_dir,
`endif
    output logic [2*N_DIR-1:0] lights,
    output logic [IDX_W-1:0]   cur_dir,
    output logic               phase_chg,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        ST_GREEN   = 2'd0,
        ST_YELLOW  = 2'd1,
        ST_ALL_RED = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0]   MIN_LIM      = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0]   MAX_LIM      = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0]   YEL_LIM      = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0]   RED_LIM      = CNT_W'(T_ALL_RED - 1);
    localparam logic [IDX_W-1:0]   HOME         = IDX_W'(HOME_DIR);
    localparam logic [2*N_DIR-1:0] RESET_LIGHTS = (2*N_DIR)'(2) << (2 * HOME_DIR);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     timer_q, timer_d;
    logic [IDX_W-1:0]     cur_dir_q, cur_dir_d;
    logic [IDX_W-1:0]     next_dir_q, next_dir_d;
    logic [2*N_DIR-1:0]   lights_q, lights_d;
    logic                 phase_chg_q, phase_chg_d;

    logic                 other_req;
    logic [IDX_W-1:0]     rr_pick;
    logic [IDX_W-1:0]     scan_idx;

    assign other_req = |(req & ~(N_DIR'(1) << cur_dir_q));

    // Scan from the far end back towards cur_dir+1 so the nearest requester wins.
    always_comb begin
        rr_pick  = cur_dir_q;
        scan_idx = '0;
        for (int k = N_DIR - 1; k >= 1; k--) begin
            scan_idx = IDX_W'((int'(cur_dir_q) + k) % N_DIR);
            if (req[scan_idx]) rr_pick = scan_idx;
        end
    end

    always_comb begin
        state_d    = state_q;
        next_dir_d = next_dir_q;
        cur_dir_d  = cur_dir_q;
`ifdef PREEMPT_EN
        if (preempt && (state_q != ST_GREEN)) next_dir_d = preempt_dir;
`endif
        case (state_q)
            ST_GREEN: begin
`ifdef PREEMPT_EN
                if (preempt) begin
                    if (preempt_dir != cur_dir_q) begin
                        state_d    = ST_YELLOW;
                        next_dir_d = preempt_dir;
                    end
                end else
`endif
                if (other_req && (((timer_q >= MIN_LIM) && !req[cur_dir_q]) || (timer_q >= MAX_LIM))) begin
                    state_d    = ST_YELLOW;
                    next_dir_d = rr_pick;
                end
            end
            ST_YELLOW: begin
                if (timer_q >= YEL_LIM) state_d = ST_ALL_RED;
            end
            ST_ALL_RED: begin
                if (timer_q >= RED_LIM) begin
                    state_d   = ST_GREEN;
                    cur_dir_d = next_dir_d;
                end
            end
            default: state_d = ST_GREEN;
        endcase

        if (state_d != state_q) timer_d = '0;
        else if (timer_q == '1)  timer_d = timer_q;
        else                     timer_d = timer_q + CNT_W'(1);

        phase_chg_d = (state_q == ST_ALL_RED) && (state_d == ST_GREEN);

        // Lamps are built from next state so the outputs can be registered without a cycle of lag.
        lights_d = '0;
        for (int i = 0; i < N_DIR; i++) begin
            if (IDX_W'(i) == cur_dir_d) begin
                if (state_d == ST_GREEN)       lights_d[2*i +: 2] = 2'b10;
                else if (state_d == ST_YELLOW) lights_d[2*i +: 2] = 2'b01;
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= ST_GREEN;
            timer_q     <= '0;
            cur_dir_q   <= HOME;
            next_dir_q  <= HOME;
            lights_q    <= RESET_LIGHTS;
            phase_chg_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cur_dir_q   <= cur_dir_d;
            next_dir_q  <= next_dir_d;
            lights_q    <= lights_d;
            phase_chg_q <= phase_chg_d;
        end
    end

    assign lights    = lights_q;
    assign cur_dir   = cur_dir_q;
    assign phase_chg = phase_chg_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_traffic_controller_nway.sv
// Bench for traffic_controller_nway: vector tables, corner-case sequences and a random run
// against a phase-counting reference model.
module tb_traffic_controller_nway;

    localparam int N = 4;
    localparam int T_MIN = 10;
    localparam int T_MAX = 40;
    localparam int T_Y = 3;
    localparam int T_AR = 2;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] req;
    logic [7:0] lights;
    logic [1:0] cur_dir;
    logic       phase_chg;
    logic [1:0] state_dbg;
`ifdef PREEMPT_EN
    logic       preempt;
    logic [1:0] preempt_dir;
`endif

    int n_checks = 0;
    int n_fail = 0;

    traffic_controller_nway dut (
        .clk        (clk),
        .clear      (clear),
        .req        (req),
`ifdef PREEMPT_EN
        .preempt    (preempt),
        .preempt_dir(preempt_dir),
`endif
        .lights     (lights),
        .cur_dir    (cur_dir),
        .phase_chg  (phase_chg),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        int         cycles;
        logic [7:0] lights;
        logic [1:0] dir;
        logic       pc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [7:0] lamp(input int dir, input logic [1:0] code);
        logic [7:0] v;
        v = '0;
        v[2*dir +: 2] = code;
        return v;
    endfunction

    function automatic void add(input logic [3:0] r, input int cyc, input logic [7:0] l,
                                input logic [1:0] d, input logic p);
        vec_t v;
        v.req = r; v.cycles = cyc; v.lights = l; v.dir = d; v.pc = p;
        tbl.push_back(v);
    endfunction

    task automatic check_out(input string name, input logic [7:0] el, input logic [1:0] ed, input logic ep);
        n_checks++;
        if (lights !== el || cur_dir !== ed || phase_chg !== ep) begin
            n_fail++;
            $display("FAIL %s t=%0t: lights=%b cur_dir=%0d phase_chg=%b, expected lights=%b cur_dir=%0d phase_chg=%b",
                     name, $time, lights, cur_dir, phase_chg, el, ed, ep);
        end
    endtask

    task automatic check_safe(input string name);
        int nonred;
        logic bad_code;
        nonred = 0;
        bad_code = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (lights[2*i +: 2] != 2'b00) nonred++;
            if (lights[2*i +: 2] == 2'b11) bad_code = 1'b1;
        end
        n_checks++;
        if (nonred > 1 || bad_code) begin
            n_fail++;
            $display("FAIL %s safety t=%0t: lights=%b has %0d non-red lamps, expected at most 1 and no code 11",
                     name, $time, lights, nonred);
        end
    endtask

    // Outputs are compared at a falling edge, then inputs for the next rising edge are driven.
    task automatic run_table(input string name);
        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].cycles; c++) begin
                check_out(name, tbl[i].lights, tbl[i].dir, tbl[i].pc);
                req = tbl[i].req;
                @(negedge clk);
            end
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        clear = 1'b1;
        req = '0;
`ifdef PREEMPT_EN
        preempt = 1'b0;
        preempt_dir = '0;
`endif
        #1;
        check_out("reset_hold", lamp(0, 2'b10), 2'd0, 1'b0);
        repeat (5) @(negedge clk);
        clear = 1'b0;
    endtask

    // Reference model: owner, green cycles shown so far, clearance cycles still to show.
    int   m_dir, m_len, m_clr, m_next;
    logic m_pc;

    function automatic void model_reset();
        m_dir = 0; m_len = 1; m_clr = 0; m_next = 0; m_pc = 1'b0;
    endfunction

    function automatic void model_step(input logic [3:0] r);
        int order[$];
        logic others;
        m_pc = 1'b0;
        if (m_clr == 0) begin
            others = 1'b0;
            for (int i = 0; i < N; i++) if (i != m_dir && r[i]) others = 1'b1;
            if (others && ((m_len >= T_MIN && !r[m_dir]) || m_len >= T_MAX)) begin
                for (int k = 1; k < N; k++) order.push_back((m_dir + k) % N);
                m_next = -1;
                foreach (order[j]) if (m_next < 0 && r[order[j]]) m_next = order[j];
                m_clr = T_Y + T_AR;
            end else if (m_len < 1000000) begin
                m_len++;
            end
        end else begin
            m_clr--;
            if (m_clr == 0) begin
                m_dir = m_next;
                m_len = 1;
                m_pc = 1'b1;
            end
        end
    endfunction

    function automatic logic [7:0] model_lights();
        if (m_clr == 0)    return lamp(m_dir, 2'b10);
        if (m_clr > T_AR)  return lamp(m_dir, 2'b01);
        return 8'h00;
    endfunction

    initial begin
        clear = 1'b1;
        req = '0;
`ifdef PREEMPT_EN
        preempt = 1'b0;
        preempt_dir = '0;
`endif

        // Idle intersection stays on the home approach.
        do_reset();
        add(4'b0000, 200, lamp(0, 2'b10), 2'd0, 1'b0);
        run_table("idle_hold");

        // Single request on approach 2: gap-out at minimum green.
        do_reset();
        add(4'b0100, 10, lamp(0, 2'b10), 2'd0, 1'b0);
        add(4'b0100, 3,  lamp(0, 2'b01), 2'd0, 1'b0);
        add(4'b0100, 2,  8'h00,          2'd0, 1'b0);
        add(4'b0100, 1,  lamp(2, 2'b10), 2'd2, 1'b1);
        add(4'b0100, 5,  lamp(2, 2'b10), 2'd2, 1'b0);
        run_table("single_req");

        // All approaches requesting: strict rotation at max green.
        do_reset();
        for (int p = 0; p < 5; p++) begin
            if (p == 0) add(4'b1111, 40, lamp(0, 2'b10), 2'd0, 1'b0);
            else begin
                add(4'b1111, 1, lamp(p % N, 2'b10), 2'(p % N), 1'b1);
                if (p < 4) add(4'b1111, 39, lamp(p % N, 2'b10), 2'(p % N), 1'b0);
            end
            if (p < 4) begin
                add(4'b1111, 3, lamp(p, 2'b01), 2'(p), 1'b0);
                add(4'b1111, 2, 8'h00, 2'(p), 1'b0);
            end
        end
        run_table("rotation");

        // Own request held blocks gap-out; the latched target survives its request dropping.
        do_reset();
        add(4'b0011, 40, lamp(0, 2'b10), 2'd0, 1'b0);
        add(4'b0001, 3,  lamp(0, 2'b01), 2'd0, 1'b0);
        add(4'b0001, 2,  8'h00,          2'd0, 1'b0);
        add(4'b0001, 1,  lamp(1, 2'b10), 2'd1, 1'b1);
        add(4'b0001, 3,  lamp(1, 2'b10), 2'd1, 1'b0);
        run_table("maxout_drop");

        // Asynchronous clear during the second yellow cycle.
        do_reset();
        add(4'b0100, 10, lamp(0, 2'b10), 2'd0, 1'b0);
        add(4'b0100, 1,  lamp(0, 2'b01), 2'd0, 1'b0);
        run_table("pre_clear");
        check_out("yellow2", lamp(0, 2'b01), 2'd0, 1'b0);
        clear = 1'b1;
        #1;
        check_out("async_clear", lamp(0, 2'b10), 2'd0, 1'b0);
        @(negedge clk);
        clear = 1'b0;
        add(4'b0100, 10, lamp(0, 2'b10), 2'd0, 1'b0);
        add(4'b0100, 3,  lamp(0, 2'b01), 2'd0, 1'b0);
        add(4'b0100, 2,  8'h00,          2'd0, 1'b0);
        add(4'b0100, 1,  lamp(2, 2'b10), 2'd2, 1'b1);
        run_table("post_clear");

`ifdef PREEMPT_EN
        // Preempt to approach 3 after three green cycles, hold, then release.
        do_reset();
        add(4'b0000, 2, lamp(0, 2'b10), 2'd0, 1'b0);
        run_table("pre_preempt");
        check_out("pre_preempt", lamp(0, 2'b10), 2'd0, 1'b0);
        preempt = 1'b1;
        preempt_dir = 2'd3;
        @(negedge clk);
        add(4'b0000, 3,  lamp(0, 2'b01), 2'd0, 1'b0);
        add(4'b0000, 2,  8'h00,          2'd0, 1'b0);
        add(4'b1111, 1,  lamp(3, 2'b10), 2'd3, 1'b1);
        add(4'b1111, 60, lamp(3, 2'b10), 2'd3, 1'b0);
        run_table("preempt_hold");
        check_out("preempt_hold", lamp(3, 2'b10), 2'd3, 1'b0);
        preempt = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        add(4'b1111, 3, lamp(3, 2'b01), 2'd3, 1'b0);
        add(4'b1111, 2, 8'h00,          2'd3, 1'b0);
        add(4'b1111, 1, lamp(0, 2'b10), 2'd0, 1'b1);
        run_table("preempt_release");
`endif

        // Randomised request patterns against the reference model.
        do_reset();
        model_reset();
        begin
            logic [3:0] r;
            int hold;
            r = '0;
            hold = 0;
            for (int c = 0; c < 4000; c++) begin
                if (hold == 0) begin
                    r = 4'($urandom_range(0, 15));
                    hold = $urandom_range(1, 60);
                end
                hold--;
                check_out("random", model_lights(), 2'(m_dir), m_pc);
                check_safe("random");
                req = r;
                model_step(r);
                @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
